pulse_burst_gen: RTL

Programmable burst pulse generator. On a start request it emits a train of `pulse_cnt` pulses, each `high_len` cycles high and separated by `low_len` cycles low. It sits directly upstream of pulse_stretch and drives its `in` port with trigger/test pulses of controlled width and spacing. It also provides busy/done status for sequencing logic.

---
 rtl/pulse_pkg.sv | 28 ++
 rtl/pulse_burst_cntr.sv | 33 +++
 rtl/pulse_burst_gen.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/pulse_pkg.sv
// Shared types and constants for the burst pulse generator.
package pulse_pkg;

    // Default width of the length/count fields and counters.
    localparam int DEFAULT_CNTR_W = 16;

    // Width of the latched config fields. Any CNTR_W up to this value is supported.
    localparam int MAX_CNTR_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } pulse_state_t;

    // Burst configuration captured on an accepted start.
    typedef struct packed {
        logic [MAX_CNTR_W-1:0] high_len;
        logic [MAX_CNTR_W-1:0] low_len;
        logic [MAX_CNTR_W-1:0] pulse_cnt;
    } pulse_cfg_t;

    // A zero gap is stretched to one cycle so adjacent pulses stay separable.
    function automatic logic [MAX_CNTR_W-1:0] eff_gap(input logic [MAX_CNTR_W-1:0] low_len);
        return (low_len == '0) ? MAX_CNTR_W'(1) : low_len;
    endfunction

endpackage

// File: rtl/pulse_burst_cntr.sv
// Loadable down-counter with a zero flag. Stops at zero instead of wrapping.
module pulse_burst_cntr #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    logic [W-1:0] count_reg;

    // Clear has priority over load, load over decrement; decrement saturates at zero.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign count = count_reg;
    assign zero  = (count_reg == '0);

endmodule

// File: rtl/pulse_burst_gen.sv
// Programmable burst pulse generator: pulse_cnt pulses of high_len cycles
// separated by max(low_len,1) low cycles, with busy/done status.
module pulse_burst_gen
    import pulse_pkg::*;
#(
    parameter int CNTR_W = DEFAULT_CNTR_W
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic              stop,
    input  logic [CNTR_W-1:0] high_len,
    input  logic [CNTR_W-1:0] low_len,
    input  logic [CNTR_W-1:0] pulse_cnt,
    output logic              out,
    output logic              busy,
    output logic              done,
    output logic [CNTR_W-1:0] pulses_left
);

    pulse_state_t      state_reg, state_next;
    pulse_cfg_t        cfg_reg, cfg_next;
    logic              out_reg, out_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;

    logic              accept;
    logic [CNTR_W-1:0] hi_reload;
    logic [CNTR_W-1:0] lo_reload;
    logic [CNTR_W-1:0] cnt_reload;

    logic              phase_clr, phase_load, phase_dec, phase_zero;
    logic [CNTR_W-1:0] phase_load_val;
    logic [CNTR_W-1:0] phase_count_unused;

    logic              pulse_clr, pulse_load, pulse_dec, pulse_zero;
    logic [CNTR_W-1:0] pulse_count;

    // Start qualification and config capture. Reload values come from cfg_next
    // so the first pulse uses the inputs present at the accepting edge.
    always_comb begin
        accept = (state_reg == IDLE) && start && !stop &&
                 (pulse_cnt != '0) && (high_len != '0);
        cfg_next = cfg_reg;
        if (accept) begin
            cfg_next.high_len  = MAX_CNTR_W'(high_len);
            cfg_next.low_len   = MAX_CNTR_W'(low_len);
            cfg_next.pulse_cnt = MAX_CNTR_W'(pulse_cnt);
        end
        hi_reload  = CNTR_W'(cfg_next.high_len - MAX_CNTR_W'(1));
        lo_reload  = CNTR_W'(eff_gap(cfg_reg.low_len) - MAX_CNTR_W'(1));
        cnt_reload = CNTR_W'(cfg_next.pulse_cnt - MAX_CNTR_W'(1));
    end

    // Next-state and counter control. Outputs default to the idle values.
    always_comb begin
        state_next = state_reg;
        out_next   = 1'b0;
        busy_next  = 1'b0;
        done_next  = 1'b0;
        phase_clr  = 1'b0;
        phase_load = 1'b0;
        phase_dec  = 1'b0;
        pulse_clr  = 1'b0;
        pulse_load = 1'b0;
        pulse_dec  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = HIGH;
                    out_next   = 1'b1;
                    busy_next  = 1'b1;
                    phase_load = 1'b1;
                    pulse_load = 1'b1;
                end
            end
            HIGH: begin
                if (stop) begin
                    state_next = IDLE;
                    phase_clr  = 1'b1;
                    pulse_clr  = 1'b1;
                end else if (phase_zero) begin
                    if (pulse_zero) begin
                        // Last high cycle: finish with no trailing gap.
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = LOW;
                        busy_next  = 1'b1;
                        phase_load = 1'b1;
                    end
                end else begin
                    out_next  = 1'b1;
                    busy_next = 1'b1;
                    phase_dec = 1'b1;
                end
            end
            LOW: begin
                if (stop) begin
                    state_next = IDLE;
                    phase_clr  = 1'b1;
                    pulse_clr  = 1'b1;
                end else if (phase_zero) begin
                    state_next = HIGH;
                    out_next   = 1'b1;
                    busy_next  = 1'b1;
                    phase_load = 1'b1;
                    pulse_dec  = 1'b1;
                end else begin
                    busy_next = 1'b1;
                    phase_dec = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                phase_clr  = 1'b1;
                pulse_clr  = 1'b1;
            end
        endcase
    end

    // Leaving HIGH loads the gap; entering HIGH (from IDLE or LOW) loads the high time.
    assign phase_load_val = (state_reg == HIGH) ? lo_reload : hi_reload;

    // FSM state, latched config and registered outputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_reg <= IDLE;
            cfg_reg   <= '0;
            out_reg   <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cfg_reg   <= cfg_next;
            out_reg   <= out_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    pulse_burst_cntr #(.W(CNTR_W)) u_phase_cntr (
        .clk      (clk),
        .nrst     (nrst),
        .clr      (phase_clr),
        .load     (phase_load),
        .load_val (phase_load_val),
        .dec      (phase_dec),
        .count    (phase_count_unused),
        .zero     (phase_zero)
    );

    pulse_burst_cntr #(.W(CNTR_W)) u_pulse_cntr (
        .clk      (clk),
        .nrst     (nrst),
        .clr      (pulse_clr),
        .load     (pulse_load),
        .load_val (cnt_reload),
        .dec      (pulse_dec),
        .count    (pulse_count),
        .zero     (pulse_zero)
    );

    assign out         = out_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign pulses_left = pulse_count;

endmodule
